// File: rtl/mcyc_pkg.sv
// Shared encodings for the minisys32 multi-cycle control sequencer.
// States, opcode/funct constants, pc_src and wb_sel values.
package mcyc_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_ERR    = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    C_R,
    C_JR,
    C_I,
    C_LW,
    C_SW,
    C_BEQ,
    C_BNE,
    C_J,
    C_JAL,
    C_BAD
  } iclass_e;

  localparam logic [5:0] OP_R     = 6'h00;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] OP_I_LO  = 6'h08;
  localparam logic [5:0] OP_I_HI  = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_JR     = 2'd3;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_LINK = 2'd2;

endpackage

// File: rtl/mcyc_watchdog.sv
// Bus-timeout watchdog: counts cycles a request waits without ready.
// Ports: clk, rst, req_active, ready in; expired out. TIMEOUT=0 disables.
module mcyc_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic req_active,
  input  logic ready,
  output logic expired
);

  if (TIMEOUT > 0) begin : g_wd
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Fires on the TIMEOUT-th waiting cycle, ready or not.
    assign expired = req_active && (cnt_q == LAST);

    // Idle or ready keeps the count at zero, so every new
    // request starts from a clean count.
    always_comb begin
      cnt_d = cnt_q;
      if (!req_active || ready || expired) cnt_d = '0;
      else                                 cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
    end
  end else begin : g_no_wd
    logic unused_wd;
    assign unused_wd = ^{clk, rst, req_active, ready};
    assign expired   = 1'b0;
  end

endmodule

// File: rtl/mcyc_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for minisys32.
// In: en, opcode, funct, zero, imem_ready, dmem_ready. Out: memory
// requests, PC/IR/regfile strobes, state, err, cycle_cnt, instr_cnt.
// MCYC_PERF_CNT_EN builds the performance counters; otherwise 0.
module mcyc_ctrl
  import mcyc_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_write,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             instr_done,
  output logic [2:0]       state,
  output logic             err,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  state_e  state_q, state_d;
  iclass_e cls;
  logic    req_active;
  logic    ready;
  logic    expired;
  logic    retire;

  always_comb begin
    cls = C_BAD;
    unique case (1'b1)
      (opcode == OP_R && funct == FN_JR): cls = C_JR;
      (opcode == OP_R && funct != FN_JR): cls = C_R;
      (opcode >= OP_I_LO
        && opcode <= OP_I_HI):            cls = C_I;
      (opcode == OP_LW):                  cls = C_LW;
      (opcode == OP_SW):                  cls = C_SW;
      (opcode == OP_BEQ):                 cls = C_BEQ;
      (opcode == OP_BNE):                 cls = C_BNE;
      (opcode == OP_J):                   cls = C_J;
      (opcode == OP_JAL):                 cls = C_JAL;
      default:                            cls = C_BAD;
    endcase
  end

  assign req_active = (state_q == S_FETCH)
                   || (state_q == S_MEM);
  assign ready = (state_q == S_MEM) ? dmem_ready
                                    : imem_ready;

  mcyc_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wd (
    .clk       (clk),
    .rst       (rst),
    .req_active(req_active),
    .ready     (ready),
    .expired   (expired)
  );

  always_comb begin
    state_d    = state_q;
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    reg_write  = 1'b0;
    wb_sel     = WB_ALU;
    pc_src     = PC_PLUS4;
    retire     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (expired) begin
          state_d = S_ERR;
        end else if (imem_ready) begin
          ir_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        unique case (1'b1)
          (cls == C_J): begin
            pc_src = PC_JUMP;
            retire = 1'b1;
          end
          (cls == C_JAL): begin
            pc_src    = PC_JUMP;
            reg_write = 1'b1;
            wb_sel    = WB_LINK;
            retire    = 1'b1;
          end
          (cls == C_JR): begin
            pc_src = PC_JR;
            retire = 1'b1;
          end
          (cls == C_BAD): state_d = S_ERR;
          default:        state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        unique case (1'b1)
          (cls == C_BEQ): begin
            pc_src = zero ? PC_BRANCH : PC_PLUS4;
            retire = 1'b1;
          end
          (cls == C_BNE): begin
            pc_src = !zero ? PC_BRANCH : PC_PLUS4;
            retire = 1'b1;
          end
          (cls == C_LW || cls == C_SW): state_d = S_MEM;
          default:                      state_d = S_WB;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls == C_SW);
        if (expired) begin
          state_d = S_ERR;
        end else if (dmem_ready) begin
          if (cls == C_SW) retire  = 1'b1;
          else             state_d = S_WB;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        wb_sel    = (cls == C_LW) ? WB_MEM : WB_ALU;
        retire    = 1'b1;
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
    // en only matters at the retire boundary; it never aborts.
    if (retire) state_d = en ? S_FETCH : S_IDLE;
  end

  assign instr_done = retire;
  assign pc_write   = retire;
  assign state      = state_q;
  assign err        = (state_q == S_ERR);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

`ifdef MCYC_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] ins_q, ins_d;

  always_comb begin
    cyc_d = cyc_q;
    ins_d = ins_q;
    if (state_q != S_IDLE && state_q != S_ERR)
      cyc_d = cyc_q + 1'b1;
    if (retire)
      ins_d = ins_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      ins_q <= ins_d;
    end
  end

  assign cycle_cnt = cyc_q;
  assign instr_cnt = ins_q;
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_mcyc_ctrl.sv
// Directed bench for mcyc_ctrl: per-cycle state/strobe checks
// against hand-derived expectations for each instruction class.
module tb_mcyc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        imem_ready;
  logic        dmem_ready;
  logic        imem_req;
  logic        ir_write;
  logic        dmem_req;
  logic        dmem_we;
  logic        reg_write;
  logic [1:0]  wb_sel;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        instr_done;
  logic [2:0]  state;
  logic        err;
  logic [31:0] cycle_cnt;
  logic [31:0] instr_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mcyc_ctrl #(
    .TIMEOUT(16),
    .CNT_W  (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .opcode    (opcode),
    .funct     (funct),
    .zero      (zero),
    .imem_ready(imem_ready),
    .dmem_ready(dmem_ready),
    .imem_req  (imem_req),
    .ir_write  (ir_write),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .reg_write (reg_write),
    .wb_sel    (wb_sel),
    .pc_write  (pc_write),
    .pc_src    (pc_src),
    .instr_done(instr_done),
    .state     (state),
    .err       (err),
    .cycle_cnt (cycle_cnt),
    .instr_cnt (instr_cnt)
  );

  task automatic chk_eq(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Check the current cycle's outputs, then move to the next cycle.
  task automatic cyc(input string tag,
                     input logic [2:0] st,
                     input logic ireq, input logic irw,
                     input logic dreq, input logic dwe,
                     input logic rw,   input logic [1:0] wbs,
                     input logic pcw,  input logic [1:0] pcs,
                     input logic done, input logic er);
    #1;
    chk_eq(tag,
      {17'd0, state, imem_req, ir_write, dmem_req, dmem_we,
       reg_write, wb_sel, pc_write, pc_src, instr_done, err},
      {17'd0, st, ireq, irw, dreq, dwe,
       rw, wbs, pcw, pcs, done, er});
    @(posedge clk);
    #1;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; en = 1'b0; opcode = '0; funct = '0;
    zero = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc("reset", 0, 0,0,0,0, 0,0, 0,0, 0,0);

    // LW, both readies immediate
    opcode = 6'h23; imem_ready = 1; dmem_ready = 1; en = 1;
    cyc("lw_idle", 0, 0,0,0,0, 0,0, 0,0, 0,0);
    cyc("lw_f",    1, 1,1,0,0, 0,0, 0,0, 0,0);
    cyc("lw_d",    2, 0,0,0,0, 0,0, 0,0, 0,0);
    cyc("lw_e",    3, 0,0,0,0, 0,0, 0,0, 0,0);
    cyc("lw_m",    4, 0,0,1,0, 0,0, 0,0, 0,0);
    en = 0;
    cyc("lw_wb",   5, 0,0,0,0, 1,1, 1,0, 1,0);

    // BEQ zero=1 taken, then BNE zero=1 not taken
    opcode = 6'h04; zero = 1; en = 1;
    cyc("beq_idle", 0, 0,0,0,0, 0,0, 0,0, 0,0);
    cyc("beq_f",    1, 1,1,0,0, 0,0, 0,0, 0,0);
    cyc("beq_d",    2, 0,0,0,0, 0,0, 0,0, 0,0);
    cyc("beq_e",    3, 0,0,0,0, 0,0, 1,1, 1,0);
    opcode = 6'h05;
    cyc("bne_f",    1, 1,1,0,0, 0,0, 0,0, 0,0);
    cyc("bne_d",    2, 0,0,0,0, 0,0, 0,0, 0,0);
    en = 0;
    cyc("bne_e",    3, 0,0,0,0, 0,0, 1,0, 1,0);

    // JAL then JR, both retire in DECODE
    opcode = 6'h03; zero = 0; en = 1;
    cyc("jal_idle", 0, 0,0,0,0, 0,0, 0,0, 0,0);
    cyc("jal_f",    1, 1,1,0,0, 0,0, 0,0, 0,0);
    cyc("jal_d",    2, 0,0,0,0, 1,2, 1,2, 1,0);
    opcode = 6'h00; funct = 6'h08;
    cyc("jr_f",     1, 1,1,0,0, 0,0, 0,0, 0,0);
    en = 0;
    cyc("jr_d",     2, 0,0,0,0, 0,0, 1,3, 1,0);
    cyc("jr_idle",  0, 0,0,0,0, 0,0, 0,0, 0,0);

    // Fetch timeout: 16 request cycles, then sticky ERR
    imem_ready = 0; en = 1;
    cyc("to_idle", 0, 0,0,0,0, 0,0, 0,0, 0,0);
    for (int i = 0; i < 16; i++)
      cyc("to_f", 1, 1,0,0,0, 0,0, 0,0, 0,0);
    imem_ready = 1;
    cyc("to_err",  6, 0,0,0,0, 0,0, 0,0, 0,1);
    cyc("to_err2", 6, 0,0,0,0, 0,0, 0,0, 0,1);
    do_rst();
    en = 0;
    cyc("to_rst",  0, 0,0,0,0, 0,0, 0,0, 0,0);

    // SW with dmem_ready 3 cycles late, en dropped in MEM
    opcode = 6'h2B; funct = 0; dmem_ready = 0; en = 1;
    cyc("sw_idle", 0, 0,0,0,0, 0,0, 0,0, 0,0);
    cyc("sw_f",    1, 1,1,0,0, 0,0, 0,0, 0,0);
    cyc("sw_d",    2, 0,0,0,0, 0,0, 0,0, 0,0);
    cyc("sw_e",    3, 0,0,0,0, 0,0, 0,0, 0,0);
    en = 0;
    for (int i = 0; i < 3; i++)
      cyc("sw_m_wait", 4, 0,0,1,1, 0,0, 0,0, 0,0);
    dmem_ready = 1;
    cyc("sw_m_rdy", 4, 0,0,1,1, 0,0, 1,0, 1,0);
    dmem_ready = 0;
    cyc("sw_end",   0, 0,0,0,0, 0,0, 0,0, 0,0);

    // Illegal opcode traps in DECODE
    opcode = 6'h3F; en = 1;
    cyc("bad_idle", 0, 0,0,0,0, 0,0, 0,0, 0,0);
    cyc("bad_f",    1, 1,1,0,0, 0,0, 0,0, 0,0);
    cyc("bad_d",    2, 0,0,0,0, 0,0, 0,0, 0,0);
    cyc("bad_err",  6, 0,0,0,0, 0,0, 0,0, 0,1);

    // Three back-to-back R-type for the counters
    do_rst();
    opcode = 6'h00; funct = 6'h20; en = 1;
    cyc("r_idle", 0, 0,0,0,0, 0,0, 0,0, 0,0);
    for (int k = 0; k < 3; k++) begin
      cyc("r_f", 1, 1,1,0,0, 0,0, 0,0, 0,0);
      cyc("r_d", 2, 0,0,0,0, 0,0, 0,0, 0,0);
      cyc("r_e", 3, 0,0,0,0, 0,0, 0,0, 0,0);
      if (k == 2) en = 0;
      cyc("r_wb", 5, 0,0,0,0, 1,0, 1,0, 1,0);
    end
    cyc("r_end", 0, 0,0,0,0, 0,0, 0,0, 0,0);
`ifdef MCYC_PERF_CNT_EN
    chk_eq("instr_cnt", instr_cnt, 32'd3);
    chk_eq("cycle_cnt", cycle_cnt, 32'd12);
`else
    chk_eq("instr_cnt", instr_cnt, 32'd0);
    chk_eq("cycle_cnt", cycle_cnt, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mcyc_ctrl.md
Name: mcyc_ctrl

Overview:
- Multi-cycle control sequencer for the next-generation minisys32 core. It replaces the single-cycle controller and the implicit one-instruction-per-clock timing.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Handshakes with instruction and data memories through req/ready.
- Drives the PC, IR, register-file and memory enables.
- A bus-timeout watchdog moves the core into a sticky error state.

Parameters:
- TIMEOUT, 16, max cycles a memory req may wait for ready before ERR; 0 disables the watchdog.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run enable; sampled at IDLE and at retire.
- opcode  in  6  Instruction[31:26].
- funct  in  6  Instruction[5:0].
- zero  in  1  ALU zero flag, valid in EXEC.
- imem_ready  in  1  instruction word valid this cycle.
- dmem_ready  in  1  data access complete this cycle.
- imem_req  out  1  instruction fetch request.
- ir_write  out  1  latch the instruction register.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data write (sw); valid only with dmem_req.
- reg_write  out  1  register-file write strobe.
- wb_sel  out  2  write-back source: 0 ALU, 1 MEM, 2 LINK.
- pc_write  out  1  PC update strobe.
- pc_src  out  2  next-PC source: 0 PC+4, 1 BRANCH, 2 JUMP, 3 JR.
- instr_done  out  1  retire pulse.
- state  out  3  current state, for debug/LED.
- err  out  1  sticky error.
- cycle_cnt  out  CNT_W  performance counter (see Optional Feature).
- instr_cnt  out  CNT_W  performance counter (see Optional Feature).

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, ERR=6.
- Outputs are combinational from state, opcode, funct, zero and the ready inputs. Every output is 0 when not asserted.
- Reset: state=IDLE, timeout counter=0, err=0. All outputs read 0 in IDLE.
- rst asserted in any state, mid-handshake included: at the next edge state=IDLE and all requests drop.
- IDLE: en=1 -> FETCH; otherwise stay.
- FETCH: imem_req=1.
  - imem_ready=1 in the same cycle (including the first req cycle): ir_write=1, next DECODE.
  - Otherwise stay.
- DECODE, one cycle. Instruction classes:
  - R = opcode 0, funct != 0x08.
  - JR = opcode 0, funct 0x08.
  - I = opcode 0x08-0x0F.
  - LW = 0x23, SW = 0x2B, BEQ = 0x04, BNE = 0x05, J = 0x02, JAL = 0x03.
  - Any other opcode -> ERR.
  - J retires here with pc_src=JUMP.
  - JAL retires here with pc_src=JUMP, reg_write=1, wb_sel=LINK.
  - JR retires here with pc_src=JR.
  - All other classes -> EXEC.
- EXEC, one cycle.
  - BEQ retires with pc_src = zero ? BRANCH : PC+4.
  - BNE retires with pc_src = !zero ? BRANCH : PC+4.
  - LW/SW -> MEM.
  - R/I -> WB.
- MEM: dmem_req=1; dmem_we=1 for SW.
  - Stays until dmem_ready=1.
  - Then SW retires (pc_src=PC+4) and LW -> WB.
- WB, one cycle: reg_write=1, wb_sel = LW ? MEM : ALU; retires with pc_src=PC+4.
- Retire cycle: instr_done=1, pc_write=1. Next state is FETCH if en=1, else IDLE.
  - en falling mid-instruction never aborts the instruction.
- Latencies with ready returned on the first req cycle:
  - J/JAL/JR: 2 cycles.
  - BEQ/BNE: 3 cycles.
  - R/I and SW: 4 cycles.
  - LW: 5 cycles.
- Watchdog (TIMEOUT>0):
  - Counter clears on entry to FETCH/MEM and on ready.
  - Counter increments each cycle the req is held without ready.
  - Reaching TIMEOUT -> ERR. The ready input is ignored on that same cycle; ERR wins.
- ERR: err=1 and all strobes 0. Exits only on rst.

Optional Feature:
- Macro: MCYC_PERF_CNT_EN.
- Defined:
  - cycle_cnt increments every cycle state is not IDLE/ERR.
  - instr_cnt increments on each instr_done.
  - Both clear on rst and wrap modulo 2^CNT_W.
- Undefined: both ports are present but tied to 0, and no counter flops are built.

Decomposition:
- Package mcyc_pkg holds:
  - state encodings;
  - opcode and funct constants (R, JR_FUNCT, LW, SW, BEQ, BNE, J, JAL, I range);
  - pc_src encodings;
  - wb_sel encodings.
- Sub-module mcyc_watchdog holds the TIMEOUT counter and the expiry flag. Inputs: clk, rst, req_active, ready. Output: expired.
- Instruction classification stays inline.

Test Plan:
- en=1, LW (0x23), imem_ready and dmem_ready returned on the first req cycle -> states 1,2,3,4,5; reg_write with wb_sel=1 in WB; instr_done and pc_write at cycle 5.
- BEQ with zero=1, then BNE with zero=1 -> first retires in EXEC with pc_src=1; second with pc_src=0; each takes 3 cycles.
- JAL (0x03) -> retires in DECODE with reg_write=1, wb_sel=2, pc_src=2. JR (opcode 0, funct 0x08) -> pc_src=3.
- TIMEOUT=16, imem_ready held 0 -> imem_req high exactly 16 cycles, then state=6 and err=1. A later imem_ready=1 is ignored; rst returns to IDLE with err=0.
- SW with dmem_ready delayed 3 cycles, en dropped during MEM -> dmem_req and dmem_we high for 4 cycles; instr_done pulses, then IDLE. Opcode 0x3F -> ERR from DECODE.
- MCYC_PERF_CNT_EN defined, 3 R-type instructions back-to-back -> instr_cnt=3, cycle_cnt=12. Macro undefined -> both counters read 0.
